// File: rtl/alu_issue_if.sv
// Instruction issue channel between the decoder and alu_issue.
// A valid/ready handshake carrying one decoded instruction.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [2:0]  in_alu_code;

  modport master (
    output in_valid,
    output in_rd,
    output in_rs1,
    output in_rs2,
    output in_imm,
    output in_use_imm,
    output in_alu_code,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_rd,
    input  in_rs1,
    input  in_rs2,
    input  in_imm,
    input  in_use_imm,
    input  in_alu_code,
    output in_ready
  );
endinterface

// File: rtl/alu_issue.sv
// Single-issue execute controller: owns the 32 x 32 register file, feeds alu,
// waits for its result (with a timeout) and writes the result back.
module alu_issue #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  in_if,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [2:0]  alu_code,
  input  logic [31:0] alu_result,
  input  logic        alu_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        err,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] exec_cnt;
  logic [31:0]   rf [32];
  logic [31:0]   rs1_val;
  logic [31:0]   rs2_val;
  logic          accept;
  logic          capture;
  logic          expire;

  assign accept = in_if.in_valid & in_if.in_ready;

  // The first EXEC cycle (counter still 0) ignores alu_ready so a ready left
  // over from the previous operation cannot be mistaken for this result.
  assign capture = (state == EXEC) && (exec_cnt != '0) && alu_ready;
  assign expire  = (state == EXEC) && !capture && (exec_cnt == CW'(TIMEOUT - 1));

  assign rs1_val   = (in_if.in_rs1 == 5'd0) ? 32'd0 : rf[in_if.in_rs1];
  assign rs2_val   = (in_if.in_rs2 == 5'd0) ? 32'd0 : rf[in_if.in_rs2];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf[dbg_raddr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        if (capture) begin
          state_nxt = WB;
        end else if (expire) begin
          state_nxt = IDLE;
        end
      end
      WB: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    in_if.in_ready = (state == IDLE) && !rst;
    busy           = (state != IDLE);
    wb_valid       = (state == WB);
  end

  // Operands are registered at accept so they stay stable for the whole EXEC
  // phase regardless of what upstream presents afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op1  <= '0;
      alu_op2  <= '0;
      alu_code <= '0;
      wb_rd    <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
      exec_cnt <= '0;
      for (int i = 0; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (accept) begin
        alu_op1  <= rs1_val;
        alu_op2  <= in_if.in_use_imm ? in_if.in_imm : rs2_val;
        alu_code <= in_if.in_alu_code;
        wb_rd    <= in_if.in_rd;
        exec_cnt <= '0;
      end else if (state == EXEC) begin
        exec_cnt <= exec_cnt + CW'(1);
      end
      if (capture) begin
        wb_data <= alu_result;
      end
      if (expire) begin
        err <= 1'b1;
      end
      if ((state == WB) && (wb_rd != 5'd0)) begin
        rf[wb_rd] <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a behavioural alu whose ready delay
// is programmable per instruction.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_code;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;
  logic        err;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  int tests     = 0;
  int fails     = 0;
  int cyc       = 0;
  int wait_cnt  = 0;
  int alu_delay = 0;

  logic [4:0]  wb_rd_log   [16];
  logic [31:0] wb_data_log [16];
  int          wb_cyc_log  [16];
  int          wb_n    = 0;
  int          run     = 0;
  int          max_run = 0;

  alu_issue_if ifc ();

  alu_issue #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (ifc),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_code   (alu_code),
    .alu_result (alu_result),
    .alu_ready  (alu_ready),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .busy       (busy),
    .err        (err),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // alu model: ready rises alu_delay cycles into the operation and stays high
  always @(posedge clk) begin
    if (!busy || wb_valid) wait_cnt <= 0;
    else                   wait_cnt <= wait_cnt + 1;
  end
  assign alu_ready  = (wait_cnt >= alu_delay);
  assign alu_result = (alu_code == 3'h1) ? alu_op1 + alu_op2 : 32'h0;

  always @(negedge clk) begin
    if (wb_valid) begin
      if (wb_n < 16) begin
        wb_rd_log[wb_n]   = wb_rd;
        wb_data_log[wb_n] = wb_data;
        wb_cyc_log[wb_n]  = cyc;
      end
      wb_n++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high after the accept edge so callers can chain requests.
  task automatic applyStimulus(input string tag, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic use_imm,
                               output int acc_cyc, output int stall);
    ifc.in_rd       = rd;
    ifc.in_rs1      = rs1;
    ifc.in_rs2      = rs2;
    ifc.in_imm      = imm;
    ifc.in_use_imm  = use_imm;
    ifc.in_alu_code = 3'h1;
    ifc.in_valid    = 1'b1;
    acc_cyc = -1;
    stall   = 0;
    for (int i = 0; i < 64; i++) begin
      if (ifc.in_ready) begin
        tick();
        acc_cyc = cyc;
        break;
      end
      stall++;
      tick();
    end
    checkOutput({tag, "_accepted"}, 32'(acc_cyc >= 0), 32'd1);
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (ifc.in_ready) break;
      tick();
    end
    checkOutput({tag, "_idle"}, 32'(ifc.in_ready), 32'd1);
  endtask

  task automatic checkReg(input string tag, input logic [4:0] idx,
                          input logic [31:0] expected);
    dbg_raddr = idx;
    #1;
    checkOutput(tag, dbg_rdata, expected);
  endtask

  int a;
  int s;
  int a1;
  int obs;
  int wbn_before;
  logic stable;

  initial begin
    ifc.in_valid    = 1'b0;
    ifc.in_rd       = '0;
    ifc.in_rs1      = '0;
    ifc.in_rs2      = '0;
    ifc.in_imm      = '0;
    ifc.in_use_imm  = 1'b0;
    ifc.in_alu_code = '0;
    dbg_raddr       = '0;

    tick();
    checkOutput("in_ready_during_reset", 32'(ifc.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", 32'(ifc.in_ready), 32'd1);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_alu_op1", alu_op1, 32'd0);
    for (int i = 0; i < 32; i++) begin
      checkReg($sformatf("reset_x%0d", i), 5'(i), 32'd0);
    end
    tick();

    applyStimulus("x1", 5'd1, 5'd0, 5'd0, 32'h40, 1'b1, a1, s);
    ifc.in_valid = 1'b0;
    waitIdle("x1");
    checkOutput("x1_wb_latency", 32'(wb_cyc_log[0] - a1), 32'd2);
    checkOutput("x1_ready_latency", 32'(cyc - a1), 32'd3);
    checkOutput("x1_wb_rd", 32'(wb_rd_log[0]), 32'd1);
    checkReg("x1_value", 5'd1, 32'h40);

    applyStimulus("x2", 5'd2, 5'd0, 5'd0, 32'h02, 1'b1, a, s);
    ifc.in_valid = 1'b0;
    waitIdle("x2");
    applyStimulus("x3", 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, a, s);
    ifc.in_valid = 1'b0;
    waitIdle("x3");
    checkOutput("x3_wb_count", 32'(wb_n), 32'd3);
    checkOutput("x3_wb_rd", 32'(wb_rd_log[2]), 32'd3);
    checkOutput("x3_wb_data", wb_data_log[2], 32'h42);
    checkReg("x3_value", 5'd3, 32'h42);

    // Back-to-back RAW with in_valid never dropped between the two requests
    applyStimulus("x4a", 5'd4, 5'd3, 5'd0, 32'h1, 1'b1, a, s);
    applyStimulus("x4b", 5'd4, 5'd4, 5'd4, 32'h0, 1'b0, a, s);
    ifc.in_valid = 1'b0;
    checkOutput("raw_not_ready_cycles", 32'(s), 32'd3);
    waitIdle("x4b");
    checkOutput("raw_first_wb_data", wb_data_log[3], 32'h43);
    checkOutput("raw_second_wb_rd", 32'(wb_rd_log[4]), 32'd4);
    checkOutput("raw_second_wb_data", wb_data_log[4], 32'h86);
    checkOutput("wb_pulse_width", 32'(max_run), 32'd1);
    checkReg("x4_value", 5'd4, 32'h86);

    applyStimulus("x0", 5'd0, 5'd1, 5'd0, 32'h5, 1'b1, a, s);
    ifc.in_valid = 1'b0;
    waitIdle("x0");
    checkOutput("x0_wb_rd", 32'(wb_rd_log[5]), 32'd0);
    checkOutput("x0_wb_data", wb_data_log[5], 32'h45);
    checkReg("x0_value", 5'd0, 32'h0);
    checkReg("x1_unchanged", 5'd1, 32'h40);
    tick();

    // Slow alu: ready appears in the 7th EXEC cycle
    alu_delay = 6;
    applyStimulus("slow", 5'd6, 5'd1, 5'd0, 32'h10, 1'b1, a, s);
    ifc.in_valid = 1'b0;
    obs    = 0;
    stable = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (!busy || wb_valid) break;
      obs++;
      if (ifc.in_ready !== 1'b0 || alu_op1 !== 32'h40 || alu_op2 !== 32'h10 ||
          alu_code !== 3'h1) stable = 1'b0;
      tick();
    end
    checkOutput("slow_exec_cycles", 32'(obs), 32'd7);
    checkOutput("slow_operands_stable", 32'(stable), 32'd1);
    waitIdle("slow");
    checkOutput("slow_wb_rd", 32'(wb_rd_log[6]), 32'd6);
    checkOutput("slow_wb_data", wb_data_log[6], 32'h50);
    checkReg("x6_value", 5'd6, 32'h50);
    checkOutput("slow_err", 32'(err), 32'd0);
    tick();

    // alu never answers: abort after 16 EXEC cycles
    alu_delay  = 1000;
    wbn_before = wb_n;
    applyStimulus("tmo", 5'd7, 5'd1, 5'd0, 32'h9, 1'b1, a, s);
    ifc.in_valid = 1'b0;
    obs = 0;
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      obs++;
      tick();
    end
    checkOutput("tmo_exec_cycles", 32'(obs), 32'd16);
    checkOutput("tmo_err", 32'(err), 32'd1);
    checkOutput("tmo_in_ready", 32'(ifc.in_ready), 32'd1);
    checkOutput("tmo_no_wb", 32'(wb_n), 32'(wbn_before));
    checkReg("x7_unchanged", 5'd7, 32'h0);
    tick();

    // Reset asserted in the settle cycle of an instruction
    alu_delay  = 0;
    wbn_before = wb_n;
    applyStimulus("rstx", 5'd5, 5'd1, 5'd0, 32'h1, 1'b1, a, s);
    ifc.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_in_ready_low", 32'(ifc.in_ready), 32'd0);
    checkOutput("rst_err_cleared", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("rst_no_wb", 32'(wb_n), 32'(wbn_before));
    checkOutput("rst_in_ready", 32'(ifc.in_ready), 32'd1);
    checkReg("x5_after_rst", 5'd5, 32'h0);
    checkReg("x1_after_rst", 5'd1, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
